// File: rtl/grid_game_core.sv
// -----------------------------------------------------------------------------
// grid_game_core
// Game logic for a single-player grid shooting game. It sits between the
// debounced buttons and the renderer / seven-segment controller.
// Features: configurable grid size, turn budget and cursor wrap mode. The ship
// map is loaded at runtime. A new game can restart at any time, and a shot at
// an already-resolved cell is rejected.
//
// Parameters
//   ROWS, COLS  grid size (2..16 each)
//   MAX_TURNS   shots per game (1..31)
//   WRAP        1: cursor wraps at edges, 0: cursor saturates at edges
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   btn_l/r/u/d/c     debounced level buttons (acted on at their rising edge)
//   new_game          pulse: (re)start a game using ship_map_flat
//   ship_map_flat     1 = ship at cell row*COLS+col (sampled in LOAD only)
//   cursor_row/col    cursor position, zero-extended to 4 bits
//   cell_status_flat  2 bits per cell: 00 unknown, 01 miss, 10 hit
//   turns_left        remaining shots
//   hits_left         ship cells not yet hit (saturates at 255)
//   shot_valid        1-cycle pulse while a shot resolves; shot_hit qualifies it
//   dup_shot          1-cycle pulse: fire on an already-resolved cell, ignored
//   win, lose         level game outcome
// -----------------------------------------------------------------------------
module grid_game_core #(
  parameter int ROWS      = 10,
  parameter int COLS      = 10,
  parameter int MAX_TURNS = 20,
  parameter int WRAP      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     btn_l,
  input  logic                     btn_r,
  input  logic                     btn_u,
  input  logic                     btn_d,
  input  logic                     btn_c,
  input  logic                     new_game,
  input  logic [ROWS*COLS-1:0]     ship_map_flat,
  output logic [3:0]               cursor_row,
  output logic [3:0]               cursor_col,
  output logic [2*ROWS*COLS-1:0]   cell_status_flat,
  output logic [4:0]               turns_left,
  output logic [7:0]               hits_left,
  output logic                     shot_valid,
  output logic                     shot_hit,
  output logic                     dup_shot,
  output logic                     win,
  output logic                     lose
);

  localparam int         N        = ROWS * COLS;
  localparam logic [3:0] ROW_MAX  = 4'(ROWS - 1);
  localparam logic [3:0] COL_MAX  = 4'(COLS - 1);
  localparam bit         WRAP_EN  = (WRAP != 0);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_PLAY    = 3'd2;
  localparam logic [2:0] S_RESOLVE = 3'd3;
  localparam logic [2:0] S_WIN     = 3'd4;
  localparam logic [2:0] S_LOSE    = 3'd5;

  logic [2:0]     state_q, state_d;
  logic [3:0]     row_q, row_d, col_q, col_d;
  logic [2*N-1:0] cells_q, cells_d;
  logic [N-1:0]   ship_q, ship_d;
  logic [4:0]     turns_q, turns_d;
  logic [8:0]     hits_q, hits_d;      // one bit wider than the output so 256-cell maps count correctly
  logic           dup_q, dup_d;
  logic [4:0]     btn_q;               // {c, d, u, r, l}

  logic [4:0]     btn_now, rise;
  logic [8:0]     cur_idx;
  logic [1:0]     tgt_status;
  logic           tgt_ship;
  logic [8:0]     map_count;

  function automatic logic [8:0] popcount(input logic [N-1:0] v);
    logic [8:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + 9'(v[i]);
    return cnt;
  endfunction

  // The edge registers track the inputs in every state. A button still held
  // across a state change or a new game therefore never produces a stale edge.
  assign btn_now   = {btn_c, btn_d, btn_u, btn_r, btn_l};
  assign rise      = btn_now & ~btn_q;
  assign cur_idx   = 9'(row_q) * 9'(COLS) + 9'(col_q);
  assign map_count = popcount(ship_map_flat);

  // The cell under the cursor is picked with a constant-index loop. This keeps
  // every select in range, whatever the grid size.
  always_comb begin
    tgt_status = 2'b00;
    tgt_ship   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cur_idx == 9'(i)) begin
        tgt_status = cells_q[2*i +: 2];
        tgt_ship   = ship_q[i];
      end
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cells_d = cells_q;
    ship_d  = ship_q;
    turns_d = turns_q;
    hits_d  = hits_q;
    dup_d   = 1'b0;

    case (state_q)
      S_IDLE: if (new_game) state_d = S_LOAD;

      S_LOAD: begin
        ship_d  = ship_map_flat;
        cells_d = '0;
        row_d   = 4'd0;
        col_d   = 4'd0;
        turns_d = 5'(MAX_TURNS);
        hits_d  = map_count;
        state_d = (map_count == 9'd0) ? S_WIN : S_PLAY;
      end

      S_PLAY: begin
        if (new_game) begin
          state_d = S_LOAD;
        end else if (rise[4]) begin
          // Fire takes priority over movement. The cursor stays put so that
          // RESOLVE updates the cell that was targeted.
          if (tgt_status != 2'b00) dup_d   = 1'b1;
          else                     state_d = S_RESOLVE;
        end else begin
          // Opposing presses cancel. The two axes are independent.
          if (rise[0] && !rise[1])
            col_d = (col_q == 4'd0)    ? (WRAP_EN ? COL_MAX : 4'd0)    : col_q - 4'd1;
          else if (rise[1] && !rise[0])
            col_d = (col_q == COL_MAX) ? (WRAP_EN ? 4'd0    : COL_MAX) : col_q + 4'd1;
          if (rise[2] && !rise[3])
            row_d = (row_q == 4'd0)    ? (WRAP_EN ? ROW_MAX : 4'd0)    : row_q - 4'd1;
          else if (rise[3] && !rise[2])
            row_d = (row_q == ROW_MAX) ? (WRAP_EN ? 4'd0    : ROW_MAX) : row_q + 4'd1;
        end
      end

      S_RESOLVE: begin
        if (new_game) begin
          state_d = S_LOAD;
        end else begin
          for (int i = 0; i < N; i++)
            if (cur_idx == 9'(i)) cells_d[2*i +: 2] = tgt_ship ? 2'b10 : 2'b01;
          turns_d = turns_q - 5'd1;
          hits_d  = hits_q - 9'(tgt_ship);
          // Sinking the last ship beats running out of turns on the same shot.
          if (hits_d == 9'd0)       state_d = S_WIN;
          else if (turns_d == 5'd0) state_d = S_LOSE;
          else                      state_d = S_PLAY;
        end
      end

      S_WIN, S_LOSE: if (new_game) state_d = S_LOAD;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the cell and ship arrays are ordinary flops and are reset along with
  // everything else. The renderer must see "unknown" on every cell straight
  // out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cells_q <= '0;
      ship_q  <= '0;
      turns_q <= '0;
      hits_q  <= '0;
      dup_q   <= 1'b0;
      btn_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cells_q <= cells_d;
      ship_q  <= ship_d;
      turns_q <= turns_d;
      hits_q  <= hits_d;
      dup_q   <= dup_d;
      btn_q   <= btn_now;
    end
  end

  assign cursor_row       = row_q;
  assign cursor_col       = col_q;
  assign cell_status_flat = cells_q;
  assign turns_left       = turns_q;
  assign hits_left        = hits_q[8] ? 8'hFF : hits_q[7:0];
  assign shot_valid       = (state_q == S_RESOLVE);
  assign shot_hit         = (state_q == S_RESOLVE) && tgt_ship;
  assign dup_shot         = dup_q;
  assign win              = (state_q == S_WIN);
  assign lose             = (state_q == S_LOSE);

endmodule
